// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Types and widths shared by the constant-operand ALU and the result FIFO
// that sits downstream of it.
//   DATA_W       : width of one ALU result
//   alu_result_t : one ALU result word together with its zero-status flag
// ---------------------------------------------------------------------------
package alu_pkg;

  localparam int DATA_W = 8;

  typedef struct packed {
    logic              status;
    logic [DATA_W-1:0] data;
  } alu_result_t;

endpackage

// File: rtl/alu_result_fifo_if.sv
// ---------------------------------------------------------------------------
// alu_result_fifo_if
// Bundles both valid/ready handshakes of the ALU result FIFO:
//   in_valid / in_data / in_status / in_ready     : ALU side (producer)
//   out_valid / out_data / out_status / out_ready : consumer side
// Modports:
//   master : the environment, which drives words in and accepts words out
//   slave  : the FIFO itself
// ---------------------------------------------------------------------------
interface alu_result_fifo_if;
  import alu_pkg::*;

  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_status;
  logic              in_ready;

  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_status;
  logic              out_ready;

  modport master (
    output in_valid, in_data, in_status, out_ready,
    input  in_ready, out_valid, out_data, out_status
  );

  modport slave (
    input  in_valid, in_data, in_status, out_ready,
    output in_ready, out_valid, out_data, out_status
  );

endinterface

// File: rtl/alu_result_fifo_ctrl.sv
// ---------------------------------------------------------------------------
// fifo_ctrl
// Pointer and occupancy bookkeeping for the ALU result FIFO.
// Ports:
//   clk, reset_n     : clock, asynchronous active-low reset
//   clear            : synchronous return to the empty state
//   pushReq, popReq  : raw in_valid / out_ready requests
//   wrPtr, rdPtr     : storage addresses, wrap modulo DEPTH
//   level            : occupancy 0..DEPTH
//   inReady          : FIFO not full
//   outValid         : FIFO not empty
//   push, pop        : qualified handshakes performed this cycle
// Full and empty come from level, never from pointer comparison, so the
// pointers can simply wrap at their natural width.
// ---------------------------------------------------------------------------
module fifo_ctrl #(
  parameter int DEPTH = 4,
  parameter int PTR_W = $clog2(DEPTH),
  parameter int LVL_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             pushReq,
  input  logic             popReq,
  output logic [PTR_W-1:0] wrPtr,
  output logic [PTR_W-1:0] rdPtr,
  output logic [LVL_W-1:0] level,
  output logic             inReady,
  output logic             outValid,
  output logic             push,
  output logic             pop
);

  // inReady deliberately ignores popReq: a full FIFO refuses a push even
  // when the head is leaving in the same cycle.
  assign inReady  = (level != LVL_W'(DEPTH));
  assign outValid = (level != '0);
  assign push     = pushReq && inReady;
  assign pop      = popReq && outValid;

  // Pointer and level registers; clear wins over any same-cycle handshake.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wrPtr <= '0;
      rdPtr <= '0;
      level <= '0;
    end else if (clear) begin
      wrPtr <= '0;
      rdPtr <= '0;
      level <= '0;
    end else begin
      if (push) wrPtr <= wrPtr + 1'b1;
      if (pop)  rdPtr <= rdPtr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/alu_result_fifo.sv
// ---------------------------------------------------------------------------
// alu_result_fifo
// First-word-fall-through buffer for ALU results, with running statistics.
// Ports:
//   clk, reset_n   : clock, asynchronous active-low reset
//   clear          : synchronous clear of contents and statistics
//   bus            : in_* / out_* handshakes (slave side)
//   level          : current occupancy 0..DEPTH
//   zero_count     : accepted words flagged zero, saturating
//   peak_value     : largest accepted result (unsigned)
//   overflow_seen  : sticky, a word was offered while full
// ---------------------------------------------------------------------------
module alu_result_fifo
  import alu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     clear,
  alu_result_fifo_if.slave         bus,
  output logic [$clog2(DEPTH):0]   level,
  output logic [CNT_W-1:0]         zero_count,
  output logic [DATA_W-1:0]        peak_value,
  output logic                     overflow_seen
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0] wrPtr;
  logic [PTR_W-1:0] rdPtr;
  logic             inReady;
  logic             outValid;
  logic             push;
  logic             pop;
  alu_result_t      storage [DEPTH];
  alu_result_t      head;

  fifo_ctrl #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W),
    .LVL_W (PTR_W + 1)
  ) ctrl (
    .clk      (clk),
    .reset_n  (reset_n),
    .clear    (clear),
    .pushReq  (bus.in_valid),
    .popReq   (bus.out_ready),
    .wrPtr    (wrPtr),
    .rdPtr    (rdPtr),
    .level    (level),
    .inReady  (inReady),
    .outValid (outValid),
    .push     (push),
    .pop      (pop)
  );

  // Storage needs no reset; an empty FIFO masks its contents below.
  always_ff @(posedge clk) begin
    if (push && !clear) storage[wrPtr] <= '{status: bus.in_status, data: bus.in_data};
  end

  // The head comes only from storage, so there is no in_* to out_* path,
  // and it reads as zero whenever the FIFO is empty.
  assign head           = outValid ? storage[rdPtr] : '0;
  assign bus.out_valid  = outValid;
  assign bus.out_data   = head.data;
  assign bus.out_status = head.status;
  assign bus.in_ready   = inReady;

  // Statistics track only accepted pushes, except overflow_seen which
  // records any offer made while full.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      zero_count    <= '0;
      peak_value    <= '0;
      overflow_seen <= 1'b0;
    end else if (clear) begin
      zero_count    <= '0;
      peak_value    <= '0;
      overflow_seen <= 1'b0;
    end else begin
      if (push && bus.in_status && (zero_count != '1)) zero_count <= zero_count + 1'b1;
      if (push && (bus.in_data > peak_value))          peak_value <= bus.in_data;
      if (bus.in_valid && !inReady)                    overflow_seen <= 1'b1;
    end
  end

  // pop is produced by the controller for its own pointer update only.
  logic unusedPop;
  assign unusedPop = pop;

endmodule

// File: tb/tb_alu_result_fifo.sv
// ---------------------------------------------------------------------------
// tb_alu_result_fifo
// Directed bench for alu_result_fifo (DEPTH=4, CNT_W=8): asynchronous reset
// mid-operation, a table of single-cycle vectors covering fill, overflow,
// ordering, simultaneous push/pop, clear priority and statistics, then
// hand-written sequences for counter saturation and pointer wrap.
// ---------------------------------------------------------------------------
module tb_alu_result_fifo;

  logic       clk;
  logic       reset_n;
  logic       clear;
  logic [2:0] level;
  logic [7:0] zero_count;
  logic [7:0] peak_value;
  logic       overflow_seen;

  alu_result_fifo_if bus();

  alu_result_fifo #(
    .DEPTH (4),
    .CNT_W (8)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .clear         (clear),
    .bus           (bus),
    .level         (level),
    .zero_count    (zero_count),
    .peak_value    (peak_value),
    .overflow_seen (overflow_seen)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       inValid;
    logic [7:0] inData;
    logic       inStatus;
    logic       outReady;
    logic       clr;
    int         expLevel;
    logic       expOutValid;
    logic [7:0] expOutData;
    logic       expOutStatus;
    logic       expInReady;
    logic       expOvf;
    int         expZero;
    int         expPeak;
  } vec_t;

  vec_t vecs[$];
  int   passCount  = 0;
  int   checkCount = 0;

  // One comparison: counts it, and reports a FAIL line on mismatch.
  task automatic checkOutput(input string name, input int actual, input int expected);
    checkCount++;
    if (actual == expected) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
  endtask

  // Drive one cycle of inputs, clock it in, and settle 1 ns past the edge.
  task automatic applyStimulus(input logic iv, input logic [7:0] d, input logic st,
                               input logic ordy, input logic clr);
    bus.in_valid  = iv;
    bus.in_data   = d;
    bus.in_status = st;
    bus.out_ready = ordy;
    clear         = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic addVec(input logic iv, input logic [7:0] d, input logic st, input logic ordy,
                        input logic clr, input int lvl, input logic ov, input logic [7:0] od,
                        input logic os, input logic ir, input logic ovf, input int z, input int pk);
    vec_t v;
    v = '{iv, d, st, ordy, clr, lvl, ov, od, os, ir, ovf, z, pk};
    vecs.push_back(v);
  endtask

  initial begin
    int sentIdx;
    int recvIdx;
    int gaps;
    int cycles;
    logic willPush;
    logic willPop;

    bus.in_valid  = 1'b0;
    bus.in_data   = 8'h00;
    bus.in_status = 1'b0;
    bus.out_ready = 1'b0;
    clear         = 1'b0;
    reset_n       = 1'b0;
    #12;
    checkOutput("reset level", int'(level), 0);
    checkOutput("reset out_valid", int'(bus.out_valid), 0);
    checkOutput("reset in_ready", int'(bus.in_ready), 1);
    checkOutput("reset out_data", int'(bus.out_data), 0);
    checkOutput("reset overflow_seen", int'(overflow_seen), 0);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Reset asserted mid-operation with three words held.
    applyStimulus(1, 8'h00, 1, 0, 0);
    applyStimulus(1, 8'h20, 0, 0, 0);
    applyStimulus(1, 8'h00, 1, 0, 0);
    checkOutput("pre-reset level", int'(level), 3);
    checkOutput("pre-reset zero_count", int'(zero_count), 2);
    bus.in_valid = 1'b0;
    #3;
    reset_n = 1'b0;
    #1;
    checkOutput("async reset level", int'(level), 0);
    checkOutput("async reset out_valid", int'(bus.out_valid), 0);
    checkOutput("async reset in_ready", int'(bus.in_ready), 1);
    checkOutput("async reset zero_count", int'(zero_count), 0);
    checkOutput("async reset peak_value", int'(peak_value), 0);
    checkOutput("async reset out_data", int'(bus.out_data), 0);
    #2;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    applyStimulus(1, 8'h05, 0, 0, 0);
    checkOutput("first push out_valid", int'(bus.out_valid), 1);
    checkOutput("first push out_data", int'(bus.out_data), 8'h05);
    checkOutput("first push out_status", int'(bus.out_status), 0);
    applyStimulus(0, 8'h00, 0, 1, 0);
    checkOutput("first pop level", int'(level), 0);

    // Vector table, starting empty with peak 0x05 and zero_count 0.
    //     iv d     st or clr  lvl ov od    os ir ovf z  peak
    addVec(1, 8'h01, 0, 0, 0,  1,  1, 8'h01, 0, 1, 0, 0, 8'h05);
    addVec(1, 8'h02, 0, 0, 0,  2,  1, 8'h01, 0, 1, 0, 0, 8'h05);
    addVec(1, 8'h03, 0, 0, 0,  3,  1, 8'h01, 0, 1, 0, 0, 8'h05);
    addVec(1, 8'h04, 0, 0, 0,  4,  1, 8'h01, 0, 0, 0, 0, 8'h05);
    addVec(1, 8'h09, 0, 0, 0,  4,  1, 8'h01, 0, 0, 1, 0, 8'h05);
    addVec(0, 8'h00, 0, 1, 0,  3,  1, 8'h02, 0, 1, 1, 0, 8'h05);
    addVec(0, 8'h00, 0, 1, 0,  2,  1, 8'h03, 0, 1, 1, 0, 8'h05);
    addVec(0, 8'h00, 0, 1, 0,  1,  1, 8'h04, 0, 1, 1, 0, 8'h05);
    addVec(0, 8'h00, 0, 1, 0,  0,  0, 8'h00, 0, 1, 1, 0, 8'h05);
    addVec(1, 8'h0A, 0, 0, 0,  1,  1, 8'h0A, 0, 1, 1, 0, 8'h0A);
    addVec(1, 8'h0B, 0, 0, 0,  2,  1, 8'h0A, 0, 1, 1, 0, 8'h0B);
    addVec(1, 8'h0C, 0, 1, 0,  2,  1, 8'h0B, 0, 1, 1, 0, 8'h0C);
    addVec(1, 8'h0D, 0, 1, 0,  2,  1, 8'h0C, 0, 1, 1, 0, 8'h0D);
    addVec(1, 8'h0E, 0, 1, 0,  2,  1, 8'h0D, 0, 1, 1, 0, 8'h0E);
    addVec(1, 8'h0F, 0, 1, 0,  2,  1, 8'h0E, 0, 1, 1, 0, 8'h0F);
    addVec(1, 8'h10, 0, 1, 0,  2,  1, 8'h0F, 0, 1, 1, 0, 8'h10);
    addVec(1, 8'h11, 0, 0, 0,  3,  1, 8'h0F, 0, 1, 1, 0, 8'h11);
    addVec(1, 8'h12, 0, 0, 0,  4,  1, 8'h0F, 0, 0, 1, 0, 8'h12);
    addVec(1, 8'h13, 0, 1, 0,  3,  1, 8'h10, 0, 1, 1, 0, 8'h12);
    addVec(1, 8'h20, 1, 1, 1,  0,  0, 8'h00, 0, 1, 0, 0, 8'h00);
    addVec(1, 8'h00, 1, 1, 0,  1,  1, 8'h00, 1, 1, 0, 1, 8'h00);
    addVec(1, 8'h00, 1, 1, 0,  1,  1, 8'h00, 1, 1, 0, 2, 8'h00);
    addVec(1, 8'h00, 1, 1, 0,  1,  1, 8'h00, 1, 1, 0, 3, 8'h00);
    addVec(1, 8'h7F, 0, 1, 0,  1,  1, 8'h7F, 0, 1, 0, 3, 8'h7F);
    addVec(1, 8'hFE, 0, 1, 0,  1,  1, 8'hFE, 0, 1, 0, 3, 8'hFE);
    addVec(1, 8'h10, 0, 1, 0,  1,  1, 8'h10, 0, 1, 0, 3, 8'hFE);
    addVec(0, 8'h00, 0, 1, 0,  0,  0, 8'h00, 0, 1, 0, 3, 8'hFE);

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].inValid, vecs[i].inData, vecs[i].inStatus, vecs[i].outReady, vecs[i].clr);
      checkOutput($sformatf("v%0d level", i), int'(level), vecs[i].expLevel);
      checkOutput($sformatf("v%0d out_valid", i), int'(bus.out_valid), int'(vecs[i].expOutValid));
      checkOutput($sformatf("v%0d out_data", i), int'(bus.out_data), int'(vecs[i].expOutData));
      checkOutput($sformatf("v%0d out_status", i), int'(bus.out_status), int'(vecs[i].expOutStatus));
      checkOutput($sformatf("v%0d in_ready", i), int'(bus.in_ready), int'(vecs[i].expInReady));
      checkOutput($sformatf("v%0d overflow_seen", i), int'(overflow_seen), int'(vecs[i].expOvf));
      checkOutput($sformatf("v%0d zero_count", i), int'(zero_count), vecs[i].expZero);
      checkOutput($sformatf("v%0d peak_value", i), int'(peak_value), vecs[i].expPeak);
    end

    // Saturation: 260 zero results while draining continuously.
    applyStimulus(0, 8'h00, 0, 0, 1);
    for (int n = 0; n < 260; n++) applyStimulus(1, 8'h00, 1, 1, 0);
    checkOutput("saturated zero_count", int'(zero_count), 255);
    checkOutput("saturation peak_value", int'(peak_value), 0);

    // Pointer wrap: 20 words through a randomly stalling consumer.
    applyStimulus(0, 8'h00, 0, 0, 1);
    sentIdx = 0;
    recvIdx = 0;
    gaps    = 0;
    cycles  = 0;
    while (recvIdx < 20 && cycles < 400) begin
      if (level != 0 && !bus.out_valid) gaps++;
      bus.in_valid  = (sentIdx < 20);
      bus.in_data   = 8'(sentIdx);
      bus.in_status = 1'b0;
      bus.out_ready = 1'($urandom_range(0, 1));
      clear         = 1'b0;
      #1;
      willPush = bus.in_valid && bus.in_ready;
      willPop  = bus.out_valid && bus.out_ready;
      if (willPop) begin
        checkOutput($sformatf("wrap word %0d", recvIdx), int'(bus.out_data), recvIdx);
        recvIdx++;
      end
      @(posedge clk);
      #1;
      if (willPush) sentIdx++;
      cycles++;
    end
    checkOutput("wrap words received", recvIdx, 20);
    checkOutput("wrap valid gaps", gaps, 0);
    checkOutput("wrap final level", int'(level), 0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
